// File: rtl/ctrl_pkg.sv
// Shared decode definitions for decode_ctrl_pipe: opcodes, control encodings and FSM states.
// Optional M-extension decoding is enabled by defining MEXT_EN.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_MEXT   = 7'b0000001;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'b00000, ALU_SUB  = 5'b00001, ALU_AND = 5'b00010, ALU_OR  = 5'b00011,
        ALU_XOR  = 5'b00100, ALU_SLL  = 5'b00101, ALU_SRL = 5'b00110, ALU_SRA = 5'b00111,
        ALU_SLT  = 5'b01000, ALU_SLTU = 5'b01001, ALU_LUI = 5'b01111
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000, IMM_B = 3'b001, IMM_S = 3'b010,
        IMM_U = 3'b011, IMM_J = 3'b100, IMM_SHAMT = 3'b101
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00, RES_LOAD = 2'b01, RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic {
        RUN = 1'b0, MDU_BUSY = 1'b1
    } state_e;

    // Controls carried into EX; ALUSrcA selects the PC as operand A (AUIPC)
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       alu_src;
        logic       alu_src_a;
        logic       jump;
        logic       branch;
        logic       jalr;
        logic [4:0] alu_ctrl;
        logic [2:0] imm_src;
        logic [1:0] result_src;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    function automatic logic [4:0] alu_arith(input logic [2:0] funct3, input logic alt, input logic is_r);
        logic [4:0] code;
        case (funct3)
            3'b000:  code = (alt && is_r) ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = alt ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            3'b111:  code = ALU_AND;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational instruction decoder for decode_ctrl_pipe.
// MEXT_EN selects M-extension decoding of R-type funct7=0000001; otherwise it is illegal.
module ctrl_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output ctrl_t      ctrl,
    output logic       is_mop,
    output logic       uses_rs1,
    output logic       uses_rs2
);

    // Opcode decode; anything unrecognised becomes an illegal, write-free instruction
    always_comb begin
        ctrl     = CTRL_NONE;
        is_mop   = 1'b0;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        case (op)
            OP_R: begin
                if (funct7 == F7_MEXT) begin
`ifdef MEXT_EN
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_ctrl  = {2'b10, funct3};
                    is_mop         = 1'b1;
                    uses_rs2       = 1'b1;
`else
                    ctrl.illegal   = 1'b1;
                    uses_rs1       = 1'b0;
`endif
                end else begin
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_ctrl  = alu_arith(funct3, funct7[5], 1'b1);
                    uses_rs2       = 1'b1;
                end
            end
            OP_I: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = alu_arith(funct3, funct7[5], 1'b0);
                ctrl.imm_src   = ((funct3 == 3'b001) || (funct3 == 3'b101)) ? IMM_SHAMT : IMM_I;
            end
            OP_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_LOAD;
            end
            OP_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.imm_src   = IMM_S;
                uses_rs2       = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.branch   = 1'b1;
                ctrl.alu_ctrl = ALU_SUB;
                ctrl.imm_src  = IMM_B;
                uses_rs2      = 1'b1;
            end
            OP_JAL: begin
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.imm_src    = IMM_J;
                ctrl.result_src = RES_PC4;
                uses_rs1        = 1'b0;
            end
            OP_JALR: begin
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.jalr       = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_PC4;
            end
            OP_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = ALU_LUI;
                ctrl.imm_src   = IMM_U;
                uses_rs1       = 1'b0;
            end
            OP_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_src_a = 1'b1;
                ctrl.imm_src   = IMM_U;
                uses_rs1       = 1'b0;
            end
            default: begin
                ctrl.illegal = 1'b1;
                uses_rs1     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// ID->EX control pipeline register with load-use stall, multi-cycle MDU hold and flush.
// MEXT_EN enables M-extension ops and the MDU_BUSY occupancy state.
module decode_ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int MDU_LATENCY = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       valid_i,
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic [4:0] rd_i,
    input  logic       flush_i,
    output logic       ready_o,
    output logic       ex_valid_o,
    output logic       RegWrite_o,
    output logic       MemWrite_o,
    output logic       ALUSrc_o,
    output logic       ALUSrcA_o,
    output logic       Jump_o,
    output logic       Branch_o,
    output logic       Jalr_o,
    output logic [4:0] ALUControl_o,
    output logic [2:0] ImmSrc_o,
    output logic [1:0] ResultSrc_o,
    output logic [4:0] ex_rd_o,
    output logic       stall_o,
    output logic       mdu_busy_o,
    output logic       illegal_o
);

    localparam logic [3:0] MDU_LOAD  = 4'(MDU_LATENCY - 1);
    localparam bit         MDU_MULTI = (MDU_LATENCY > 1);

    ctrl_t      dec_s, ex_r, ex_nxt_s;
    logic       mop_s, use_rs1_s, use_rs2_s;
    logic       ex_valid_r, ex_valid_nxt_s;
    logic [4:0] ex_rd_r, ex_rd_nxt_s;
    state_e     state_r, state_nxt_s;
    logic [3:0] cnt_r, cnt_nxt_s;
    logic       load_use_s, stall_s, ready_s;

    ctrl_decoder u_decoder (
        .op       (op_i),
        .funct3   (funct3_i),
        .funct7   (funct7_i),
        .ctrl     (dec_s),
        .is_mop   (mop_s),
        .uses_rs1 (use_rs1_s),
        .uses_rs2 (use_rs2_s)
    );

    // Load in EX whose destination is read by the ID instruction
    always_comb begin
        load_use_s = 1'b0;
        if (valid_i && ex_valid_r && (ex_r.result_src == RES_LOAD) && (ex_rd_r != 5'd0)) begin
            load_use_s = (use_rs1_s && (rs1_i == ex_rd_r)) || (use_rs2_s && (rs2_i == ex_rd_r));
        end else begin
            load_use_s = 1'b0;
        end
    end

    assign stall_s = load_use_s || (state_r == MDU_BUSY);
    assign ready_s = !stall_s && !flush_i;

    // Next EX contents and MDU state; flush overrides both hazards
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        ex_valid_nxt_s = 1'b0;
        ex_nxt_s       = CTRL_NONE;
        ex_rd_nxt_s    = 5'd0;
        if (flush_i) begin
            state_nxt_s = RUN;
            cnt_nxt_s   = 4'd0;
        end else begin
            case (state_r)
                RUN: begin
                    if (valid_i && ready_s) begin
                        ex_valid_nxt_s = 1'b1;
                        ex_nxt_s       = dec_s;
                        ex_rd_nxt_s    = rd_i;
                        if (mop_s && MDU_MULTI) begin
                            state_nxt_s = MDU_BUSY;
                            cnt_nxt_s   = MDU_LOAD;
                        end else begin
                            state_nxt_s = RUN;
                        end
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                MDU_BUSY: begin
                    ex_valid_nxt_s = ex_valid_r;
                    ex_nxt_s       = ex_r;
                    ex_rd_nxt_s    = ex_rd_r;
                    if (cnt_r <= 4'd1) begin
                        state_nxt_s = RUN;
                        cnt_nxt_s   = 4'd0;
                    end else begin
                        cnt_nxt_s   = cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_nxt_s = RUN;
                    cnt_nxt_s   = 4'd0;
                end
            endcase
        end
    end

    // EX pipeline register and MDU state
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ex_valid_r <= 1'b0;
            ex_r       <= CTRL_NONE;
            ex_rd_r    <= 5'd0;
            state_r    <= RUN;
            cnt_r      <= 4'd0;
        end else begin
            ex_valid_r <= ex_valid_nxt_s;
            ex_r       <= ex_nxt_s;
            ex_rd_r    <= ex_rd_nxt_s;
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
        end
    end

    assign ready_o      = ready_s;
    assign stall_o      = stall_s;
    assign ex_valid_o   = ex_valid_r;
    assign RegWrite_o   = ex_r.reg_write;
    assign MemWrite_o   = ex_r.mem_write;
    assign ALUSrc_o     = ex_r.alu_src;
    assign ALUSrcA_o    = ex_r.alu_src_a;
    assign Jump_o       = ex_r.jump;
    assign Branch_o     = ex_r.branch;
    assign Jalr_o       = ex_r.jalr;
    assign ALUControl_o = ex_r.alu_ctrl;
    assign ImmSrc_o     = ex_r.imm_src;
    assign ResultSrc_o  = ex_r.result_src;
    assign ex_rd_o      = ex_rd_r;
    assign illegal_o    = ex_r.illegal;
`ifdef MEXT_EN
    assign mdu_busy_o   = (state_r == MDU_BUSY);
`else
    assign mdu_busy_o   = 1'b0;
`endif

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Randomised self-checking bench for decode_ctrl_pipe against an instruction-level model.
// Honours MEXT_EN the same way as the design.
module tb_decode_ctrl_pipe;

    localparam int LAT = 4;

    logic       clk_i = 1'b0;
    logic       rst_n_i, valid_i, flush_i;
    logic [6:0] op_i, funct7_i;
    logic [2:0] funct3_i;
    logic [4:0] rs1_i, rs2_i, rd_i;
    logic       ready_o, ex_valid_o, RegWrite_o, MemWrite_o, ALUSrc_o, ALUSrcA_o;
    logic       Jump_o, Branch_o, Jalr_o, stall_o, mdu_busy_o, illegal_o;
    logic [4:0] ALUControl_o, ex_rd_o;
    logic [2:0] ImmSrc_o;
    logic [1:0] ResultSrc_o;

    always #5 clk_i = ~clk_i;

    decode_ctrl_pipe #(.MDU_LATENCY(LAT)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .op_i(op_i),
        .funct3_i(funct3_i), .funct7_i(funct7_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .rd_i(rd_i), .flush_i(flush_i), .ready_o(ready_o), .ex_valid_o(ex_valid_o),
        .RegWrite_o(RegWrite_o), .MemWrite_o(MemWrite_o), .ALUSrc_o(ALUSrc_o),
        .ALUSrcA_o(ALUSrcA_o), .Jump_o(Jump_o), .Branch_o(Branch_o), .Jalr_o(Jalr_o),
        .ALUControl_o(ALUControl_o), .ImmSrc_o(ImmSrc_o), .ResultSrc_o(ResultSrc_o),
        .ex_rd_o(ex_rd_o), .stall_o(stall_o), .mdu_busy_o(mdu_busy_o), .illegal_o(illegal_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: what EX should hold, and how many more cycles the MDU keeps it
    logic        m_valid;
    logic [17:0] m_ctrl;
    logic [4:0]  m_rd;
    int          m_busy;

    logic        obs_stall, obs_ready, obs_busy, obs_evalid;
    logic [17:0] obs_ctrl;
    logic [4:0]  obs_rd;

    logic [4:0] alu_by_f3 [0:7] = '{5'd0, 5'd5, 5'd8, 5'd9, 5'd4, 5'd6, 5'd3, 5'd2};
    logic [6:0] legal_ops [0:8] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                    7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    // Returns {rw,mw,asrc,asrca,jump,branch,jalr,alu[5],imm[3],res[2],illegal, mop, use_rs1, use_rs2}
    function automatic logic [20:0] ref_decode(input logic [31:0] ins);
        logic rw = 0, mw = 0, as = 0, asa = 0, j = 0, b = 0, jr = 0, ill = 0, mop = 0, u1 = 1, u2 = 0;
        logic [4:0] alu = 5'd0;
        logic [2:0] imm = 3'd0;
        logic [1:0] res = 2'd0;
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        logic [4:0] arith = alu_by_f3[f3] + ((f3 == 3'b101 && f7[5]) ? 5'd1 : 5'd0);
        case (ins[6:0])
            7'b0110011: begin
                if (f7 == 7'b0000001) begin
`ifdef MEXT_EN
                    rw = 1; alu = {2'b10, f3}; mop = 1; u2 = 1;
`else
                    ill = 1; u1 = 0;
`endif
                end else begin
                    rw = 1; u2 = 1;
                    alu = arith + ((f3 == 3'b000 && f7[5]) ? 5'd1 : 5'd0);
                end
            end
            7'b0010011: begin rw = 1; as = 1; alu = arith; imm = (f3 == 3'b001 || f3 == 3'b101) ? 3'd5 : 3'd0; end
            7'b0000011: begin rw = 1; as = 1; res = 2'd1; end
            7'b0100011: begin mw = 1; as = 1; imm = 3'd2; u2 = 1; end
            7'b1100011: begin b = 1; alu = 5'd1; imm = 3'd1; u2 = 1; end
            7'b1101111: begin rw = 1; j = 1; imm = 3'd4; res = 2'd2; u1 = 0; end
            7'b1100111: begin rw = 1; j = 1; jr = 1; as = 1; res = 2'd2; end
            7'b0110111: begin rw = 1; as = 1; alu = 5'd15; imm = 3'd3; u1 = 0; end
            7'b0010111: begin rw = 1; as = 1; asa = 1; imm = 3'd3; u1 = 0; end
            default:    begin ill = 1; u1 = 0; end
        endcase
        return {rw, mw, as, asa, j, b, jr, alu, imm, res, ill, mop, u1, u2};
    endfunction

    task automatic model_clear();
        m_valid = 1'b0; m_ctrl = '0; m_rd = '0; m_busy = 0;
    endtask

    task automatic step(input logic v, input logic [31:0] ins, input logic fl);
        logic [20:0] d;
        logic lu, stall_e, ready_e;
        @(negedge clk_i);
        valid_i = v;
        flush_i = fl;
        {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, op_i} = ins;
        #1;
        obs_stall  = stall_o;
        obs_ready  = ready_o;
        obs_busy   = mdu_busy_o;
        obs_evalid = ex_valid_o;
        obs_rd     = ex_rd_o;
        obs_ctrl   = {RegWrite_o, MemWrite_o, ALUSrc_o, ALUSrcA_o, Jump_o, Branch_o, Jalr_o,
                      ALUControl_o, ImmSrc_o, ResultSrc_o, illegal_o};
        d = ref_decode(ins);
        lu = v && m_valid && (m_ctrl[2:1] == 2'b01) && (m_rd != 5'd0) &&
             ((d[1] && ins[19:15] == m_rd) || (d[0] && ins[24:20] == m_rd));
        stall_e = lu || (m_busy > 0);
        ready_e = !stall_e && !fl;
        check_val("ex_valid", obs_evalid, m_valid);
        check_val("ex_ctrl", obs_ctrl, m_ctrl);
        check_val("ex_rd", obs_rd, m_rd);
        check_val("mdu_busy", obs_busy, m_busy > 0);
        check_val("stall", obs_stall, stall_e);
        check_val("ready", obs_ready, ready_e);
        @(posedge clk_i);
        if (fl) begin
            model_clear();
        end else if (m_busy > 0) begin
            m_busy--;
        end else if (v && ready_e) begin
            m_valid = 1'b1; m_ctrl = d[20:3]; m_rd = ins[11:7];
            m_busy  = d[2] ? LAT - 1 : 0;
        end else begin
            model_clear();
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_n_i = 1'b0; valid_i = 1'b0; flush_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        model_clear();
        #1;
        check_val("rst_ex_valid", ex_valid_o, 1'b0);
        check_val("rst_ctrl", {RegWrite_o, MemWrite_o, ALUControl_o, ResultSrc_o, illegal_o, ex_rd_o}, 32'd0);
        check_val("rst_stall", stall_o, 1'b0);
        check_val("rst_busy", mdu_busy_o, 1'b0);
        check_val("rst_ready", ready_o, 1'b1);
    endtask

    localparam logic [6:0] R = 7'b0110011, LD = 7'b0000011, LUI = 7'b0110111;

    initial begin
        int busy_cnt, nready_cnt;
        logic [31:0] ins;
        rst_n_i = 1'b0; valid_i = 1'b0; flush_i = 1'b0;
        {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, op_i} = 32'd0;
        model_clear();
        do_reset();

        // add x3,x1,x2 then sub x4,x1,x2
        step(1'b1, enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, R), 1'b0);
        step(1'b1, enc(7'h20, 5'd2, 5'd1, 3'd0, 5'd4, R), 1'b0);
        check_val("add_alu", obs_ctrl[10:6], 5'b00000);
        check_val("add_nostall", obs_stall, 1'b0);
        step(1'b0, 32'd0, 1'b0);
        check_val("sub_alu", obs_ctrl[10:6], 5'b00001);
        check_val("sub_regwrite", obs_ctrl[17], 1'b1);

        // lw x5,0(x1); add x6,x5,x2 -> one stall, one bubble
        step(1'b1, enc(7'h00, 5'd0, 5'd1, 3'd2, 5'd5, LD), 1'b0);
        step(1'b1, enc(7'h00, 5'd2, 5'd5, 3'd0, 5'd6, R), 1'b0);
        check_val("lu_stall", obs_stall, 1'b1);
        check_val("lu_ready", obs_ready, 1'b0);
        step(1'b1, enc(7'h00, 5'd2, 5'd5, 3'd0, 5'd6, R), 1'b0);
        check_val("lu_bubble", obs_evalid, 1'b0);
        check_val("lu_one_cycle", obs_stall, 1'b0);
        step(1'b0, 32'd0, 1'b0);
        check_val("lu_add_rd", obs_rd, 5'd6);

        // lw x0 then add using x0; lw x5 then lui x7 (rs1 field aliases x5)
        step(1'b1, enc(7'h00, 5'd0, 5'd1, 3'd2, 5'd0, LD), 1'b0);
        step(1'b1, enc(7'h00, 5'd2, 5'd0, 3'd0, 5'd6, R), 1'b0);
        check_val("x0_nostall", obs_stall, 1'b0);
        step(1'b1, enc(7'h00, 5'd0, 5'd1, 3'd2, 5'd5, LD), 1'b0);
        step(1'b1, enc(7'h00, 5'd0, 5'd5, 3'd0, 5'd7, LUI), 1'b0);
        check_val("lui_nostall", obs_stall, 1'b0);

        // Undecodable opcode and mul
        step(1'b1, enc(7'h00, 5'd0, 5'd0, 3'd0, 5'd9, 7'b1111111), 1'b0);
        step(1'b1, enc(7'h01, 5'd2, 5'd1, 3'd0, 5'd8, R), 1'b0);
        check_val("ill_valid", obs_evalid, 1'b1);
        check_val("ill_flag", obs_ctrl[0], 1'b1);
        check_val("ill_nowrite", {obs_ctrl[17], obs_ctrl[16]}, 2'b00);
        busy_cnt = 0; nready_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, R), 1'b0);
            if (i == 0) begin
`ifdef MEXT_EN
                check_val("mul_alu", obs_ctrl[10:6], 5'b10000);
`else
                check_val("mul_illegal", obs_ctrl[0], 1'b1);
`endif
            end
            busy_cnt += int'(obs_busy);
            nready_cnt += int'(!obs_ready);
        end
`ifdef MEXT_EN
        check_val("mul_busy_cycles", busy_cnt, 3);
        check_val("mul_nready_cycles", nready_cnt, 3);
        // flush during MDU_BUSY
        step(1'b1, enc(7'h01, 5'd2, 5'd1, 3'd0, 5'd8, R), 1'b0);
        step(1'b0, 32'd0, 1'b0);
        step(1'b0, 32'd0, 1'b1);
        check_val("flush_busy_pre", obs_busy, 1'b1);
        step(1'b0, 32'd0, 1'b0);
        check_val("flush_ex_valid", obs_evalid, 1'b0);
        check_val("flush_busy", obs_busy, 1'b0);
        check_val("flush_ready", obs_ready, 1'b1);
        // reset mid-MDU_BUSY
        step(1'b1, enc(7'h01, 5'd2, 5'd1, 3'd4, 5'd8, R), 1'b0);
        step(1'b0, 32'd0, 1'b0);
        check_val("rst_pre_busy", obs_busy, 1'b1);
        do_reset();
`else
        check_val("mul_busy_cycles", busy_cnt, 0);
        check_val("mul_nready_cycles", nready_cnt, 0);
`endif

        // Random traffic with a small register set to provoke hazards
        for (int n = 0; n < 1500; n++) begin
            ins = $urandom;
            ins[6:0] = legal_ops[$urandom_range(0, 8)];
            case ($urandom_range(0, 5))
                0: ins[31:25] = 7'h00;
                1: ins[31:25] = 7'h20;
                2: ins[31:25] = 7'h01;
                default: ins[31:25] = 7'($urandom);
            endcase
            case ($urandom_range(0, 9))
                0: ins[6:0] = 7'($urandom);
                1: ins[6:0] = R;
                2: ins[6:0] = LD;
                default: ins[6:0] = ins[6:0];
            endcase
            ins[11:7]  = 5'($urandom_range(0, 3));
            ins[19:15] = 5'($urandom_range(0, 3));
            ins[24:20] = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end
            step($urandom_range(0, 7) != 0, ins, $urandom_range(0, 15) == 0);
        end
        step(1'b0, 32'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
